uart_runner: RTL and testbench

// - UART packet engine for the iCE40 UART-ALU: receives 8N1 bytes on rx_i, parses {opcode, reserved, len_lo, len_hi, payload}, answers on tx_o.
// - Echo opcode retransmits the payload; optional ADD opcode returns a 32-bit sum. Top-level block between board pins and host.

---
 rtl/uart_runner_pkg.sv | 26 ++
 rtl/uart_runner_phy.sv | 169 ++++++++++++++++
 rtl/uart_runner.sv | 186 ++++++++++++++++++
 tb/tb_uart_runner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_runner_pkg.sv
// rtl/uart_runner_pkg.sv - shared opcodes, sizes and state types for the UART packet engine
package uart_runner_pkg;

    localparam logic [7:0] OPC_ECHO   = 8'hEC;
    localparam logic [7:0] OPC_ADD    = 8'hA0;
    localparam int         HDR_BYTES  = 4;
    localparam int         FIFO_DEPTH = 4;
    localparam int         FIFO_AW    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PHY_IDLE,
        PHY_START,
        PHY_DATA,
        PHY_STOP
    } phy_state_e;

endpackage

// File: rtl/uart_runner_phy.sv
// rtl/uart_runner_phy.sv - 8N1 receiver with input synchronizer and 8N1 transmitter
module uart_runner_phy
    import uart_runner_pkg::*;
#(
    parameter int PRESCALE = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       frame_err_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] HALF = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    phy_state_e      rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;

    phy_state_e      tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;

    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_shift_q;
    assign frame_err_o = frame_err_q;
    assign tx_o        = tx_q;
    assign tx_busy_o   = (tx_state_q != PHY_IDLE);
    // Accepting during the last stop-bit clock lets queued bytes go out with no idle gap.
    assign tx_ready_o  = (tx_state_q == PHY_IDLE) || (tx_state_q == PHY_STOP && tx_cnt_q == LAST);

    always_comb begin
        rx_meta_d   = rx_i;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            PHY_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q && rx_prev_q) rx_state_d = PHY_START;
            end
            PHY_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? PHY_IDLE : PHY_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + ONE;
                end
            end
            PHY_DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = PHY_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + ONE;
                end
            end
            default: begin
                if (rx_cnt_q == LAST) begin
                    rx_state_d  = PHY_IDLE;
                    rx_valid_d  = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + ONE;
                end
            end
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            PHY_IDLE: tx_cnt_d = '0;
            PHY_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = PHY_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + ONE;
                end
            end
            PHY_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = PHY_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + ONE;
                end
            end
            default: begin
                if (tx_cnt_q == LAST) tx_state_d = PHY_IDLE;
                else                  tx_cnt_d   = tx_cnt_q + ONE;
            end
        endcase
        if (tx_valid_i && tx_ready_o) begin
            tx_state_d = PHY_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_data_i;
        end
        case (tx_state_d)
            PHY_START: tx_d = 1'b0;
            PHY_DATA:  tx_d = tx_shift_d[0];
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= PHY_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= PHY_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: rtl/uart_runner.sv
// rtl/uart_runner.sv - UART packet engine: header parse, echo, optional ADD (UART_RUNNER_ADD_EN)
module uart_runner
    import uart_runner_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic tx_o,
    output logic busy_o,
    output logic frame_err_o
);

    localparam int                PRESCALE  = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam logic [FIFO_AW:0]  FIFO_FULL = FIFO_DEPTH[FIFO_AW:0];
    localparam logic [15:0]       HDR_LEN   = HDR_BYTES[15:0];

    logic       rx_valid, tx_valid, tx_ready, tx_busy;
    logic [7:0] rx_data, tx_data;

    uart_runner_phy #(.PRESCALE(PRESCALE)) u_phy (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .rx_valid_o  (rx_valid),
        .rx_data_o   (rx_data),
        .frame_err_o (frame_err_o),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
        .tx_ready_o  (tx_ready),
        .tx_o        (tx_o),
        .tx_busy_o   (tx_busy)
    );

    state_e       state_q, state_d;
    logic [7:0]   opcode_q, opcode_d, len_lo_q, len_lo_d, echo_data_q, echo_data_d;
    logic [15:0]  remain_q, remain_d, len;
    logic         echo_push_q, echo_push_d, push;
    logic [7:0]   push_data;
    logic [7:0]   mem_q [FIFO_DEPTH];
    logic [7:0]   mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;
`ifdef UART_RUNNER_ADD_EN
    logic [23:0]  acc_q, acc_d;
    logic [31:0]  sum_q, sum_d;
    logic [1:0]   grp_q, grp_d, done_idx_q, done_idx_d;
`endif

    assign busy_o   = (state_q != ST_IDLE) || (cnt_q != '0) || tx_busy || echo_push_q;
    assign tx_valid = (cnt_q != '0);
    assign tx_data  = mem_q[rd_q];
    assign len      = {rx_data, len_lo_q};

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        len_lo_d    = len_lo_q;
        remain_d    = remain_q;
        echo_push_d = 1'b0;
        echo_data_d = echo_data_q;
        push        = echo_push_q;
        push_data   = echo_data_q;
`ifdef UART_RUNNER_ADD_EN
        acc_d       = acc_q;
        sum_d       = sum_q;
        grp_d       = grp_q;
        done_idx_d  = done_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef UART_RUNNER_ADD_EN
                sum_d      = '0;
                grp_d      = '0;
                done_idx_d = '0;
`endif
                if (rx_valid) begin
                    opcode_d = rx_data;
                    state_d  = ST_RSVD;
                end
            end
            ST_RSVD:   if (rx_valid) state_d = ST_LEN_LO;
            ST_LEN_LO: if (rx_valid) begin
                len_lo_d = rx_data;
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (rx_valid) begin
                remain_d = len - HDR_LEN;
                state_d  = (len <= HDR_LEN) ? ST_DONE : ST_PAYLOAD;
            end
            ST_PAYLOAD: if (rx_valid) begin
                if (opcode_q == OPC_ECHO) begin
                    echo_push_d = 1'b1;
                    echo_data_d = rx_data;
                end
`ifdef UART_RUNNER_ADD_EN
                // Operands are assembled LSB first; the fourth byte completes the add.
                if (opcode_q == OPC_ADD) begin
                    grp_d = grp_q + 2'd1;
                    case (grp_q)
                        2'd0:    acc_d[7:0]   = rx_data;
                        2'd1:    acc_d[15:8]  = rx_data;
                        2'd2:    acc_d[23:16] = rx_data;
                        default: sum_d        = sum_q + {rx_data, acc_q};
                    endcase
                end
`endif
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef UART_RUNNER_ADD_EN
                if (opcode_q == OPC_ADD) begin
                    push       = 1'b1;
                    push_data  = 8'(sum_q >> {done_idx_q, 3'b000});
                    done_idx_d = done_idx_q + 2'd1;
                    if (done_idx_q != 2'd3) state_d = ST_DONE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_push = push && (cnt_q != FIFO_FULL);
        do_pop  = tx_valid && tx_ready;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            remain_q    <= '0;
            echo_push_q <= 1'b0;
            echo_data_q <= '0;
            mem_q       <= '{default: '0};
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
`ifdef UART_RUNNER_ADD_EN
            acc_q       <= '0;
            sum_q       <= '0;
            grp_q       <= '0;
            done_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            remain_q    <= remain_d;
            echo_push_q <= echo_push_d;
            echo_data_q <= echo_data_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
`ifdef UART_RUNNER_ADD_EN
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            grp_q       <= grp_d;
            done_idx_q  <= done_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_runner.sv
// tb/tb_uart_runner.sv - scoreboard bench for uart_runner driving 8N1 packets and decoding tx_o
module tb_uart_runner;

    localparam int BIT_CLKS = 104;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic rx_i  = 1'b1;
    logic tx_o, busy_o, frame_err_o;

    int checks    = 0;
    int errors    = 0;
    int unexp_cnt = 0;
    int fe_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];

    always #5 clk_i = ~clk_i;

    uart_runner dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (BIT_CLKS) @(posedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (BIT_CLKS) @(posedge clk_i);
        end
        rx_i = stop_bit;
        repeat (BIT_CLKS) @(posedge clk_i);
        rx_i = 1'b1;
        if (!stop_bit) repeat (BIT_CLKS) @(posedge clk_i);
    endtask

    task automatic send_pkt(input logic [7:0] p[$]);
        foreach (p[i]) send_byte(p[i], 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk_i);
        while (busy_o !== 1'b0 && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_unexpected"}, unexp_cnt, 0);
    endtask

    // Decode tx_o at mid-bit and score each byte against the expected queue.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk_i);
            if (tx_o === 1'b0) begin
                repeat (BIT_CLKS / 2 - 1) @(negedge clk_i);
                check_eq("tx_start_bit", 32'(tx_o), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk_i);
                    b[i] = tx_o;
                end
                repeat (BIT_CLKS) @(negedge clk_i);
                check_eq("tx_stop_bit", 32'(tx_o), 32'd1);
                if (exp_q.size() > 0) check_eq("tx_byte", 32'(b), 32'(exp_q.pop_front()));
                else unexp_cnt++;
            end
        end
    end

    always @(negedge clk_i) if (frame_err_o === 1'b1) fe_cycles++;

    initial begin : watchdog
        #(150_000 * 10);
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] r0, r1;
        int fe0;

        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_tx", 32'(tx_o), 32'd1);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err_o), 32'd0);
        rst_i = 1'b0;
        repeat (10) @(posedge clk_i);

        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
        send_pkt(pkt);
        wait_idle("echo2");

        pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
        send_pkt(pkt);
        wait_idle("echo_empty");
        exp_q.push_back(8'h41);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h41};
        send_pkt(pkt);
        wait_idle("echo_after_empty");

        pkt = '{8'hEC, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        wait_idle("len_zero");

        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(pkt);
        wait_idle("unknown_op");

`ifdef UART_RUNNER_ADD_EN
        exp_q.push_back(8'h03); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        wait_idle("add_simple");

        exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        wait_idle("add_wrap");

        repeat (4) exp_q.push_back(8'h00);
        pkt = '{8'hA0, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        send_pkt(pkt);
        wait_idle("add_partial");
`else
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(pkt);
        wait_idle("add_disabled");
`endif

        pkt = '{8'hEC, 8'h00};
        send_pkt(pkt);
        fe0 = fe_cycles;
        send_byte(8'h48, 1'b0);
        check_eq("frame_err_pulse", fe_cycles - fe0, 1);
        check_eq("frame_err_busy", 32'(busy_o), 32'd1);
        exp_q.push_back(8'h51);
        pkt = '{8'h05, 8'h00, 8'h51};
        send_pkt(pkt);
        wait_idle("after_frame_err");

        pkt = '{8'hEC, 8'h00};
        send_pkt(pkt);
        @(negedge clk_i);
        check_eq("midpkt_busy", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("midrst_tx", 32'(tx_o), 32'd1);
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        exp_q.push_back(8'h7A);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7A};
        send_pkt(pkt);
        wait_idle("after_reset");

        r0 = 8'($urandom);
        r1 = 8'($urandom);
        exp_q.push_back(r0);
        exp_q.push_back(r1);
        pkt = '{8'hEC, 8'h5A, 8'h06, 8'h00, r0, r1};
        send_pkt(pkt);
        wait_idle("echo_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
